ctrl_pipeline: RTL and testbench

Pipelined main control unit for the RV32I core. Decodes the ID-stage opcode into the full control word, then carries the control bits through registered EX, MEM and WB stages. Load-use hazards are detected internally and inserted as bubbles. External stalls and flushes are honoured, and illegal opcodes are flagged and counted.

---
 rtl/ctrl_pipeline.sv | 179 +++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// Pipelined RV32I main control: ID decode, EX/MEM/WB control registers, load-use bubbles, illegal-opcode tracking.
// Define CTRL_SYSTEM_EN to accept FENCE and SYSTEM as legal NOPs; otherwise they count as illegal.
module ctrl_pipeline #(
  parameter int REG_ADDR_W = 5,
  parameter int ILL_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  id_jump,
  output logic                  id_branch,
  output logic                  load_use_stall_o,
  output logic                  ex_valid,
  output logic [1:0]            ex_ula_op,
  output logic [1:0]            ex_alu_src1,
  output logic [1:0]            ex_alu_src2,
  output logic                  mem_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_valid,
  output logic                  wb_reg_wr,
  output logic                  wb_mux_reg_wr,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] mem_rd_idx,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  ill_instr_o,
  output logic [ILL_CNT_W-1:0]  ill_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`ifdef CTRL_SYSTEM_EN
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

  function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] v);
    return (&v) ? v : v + ILL_CNT_W'(1);
  endfunction

  logic       dec_legal_p0, dec_reg_wr_p0, dec_mem_read_p0, dec_mem_write_p0, dec_mux_p0;
  logic [1:0] dec_ula_p0, dec_src1_p0, dec_src2_p0;
  logic       dec_jump_p0, dec_branch_p0, uses_rs1_p0, uses_rs2_p0;
  logic       ex_reg_wr, ex_mem_read, ex_mem_write, ex_mux_reg_wr;
  logic       mem_reg_wr, mem_mux_reg_wr;
  logic       bubble, consumed;

  // ID stage: opcode decode
  always_comb begin
    dec_legal_p0     = 1'b0;
    dec_reg_wr_p0    = 1'b0;
    dec_mem_read_p0  = 1'b0;
    dec_mem_write_p0 = 1'b0;
    dec_mux_p0       = 1'b0;
    dec_ula_p0       = 2'b00;
    dec_src1_p0      = 2'b00;
    dec_src2_p0      = 2'b00;
    dec_jump_p0      = 1'b0;
    dec_branch_p0    = 1'b0;
    uses_rs1_p0      = 1'b1;
    uses_rs2_p0      = 1'b0;
    case (id_opcode)
      OP_R: begin
        dec_legal_p0 = 1'b1; dec_reg_wr_p0 = 1'b1; dec_ula_p0 = 2'b10; uses_rs2_p0 = 1'b1;
      end
      OP_IALU: begin
        dec_legal_p0 = 1'b1; dec_reg_wr_p0 = 1'b1; dec_ula_p0 = 2'b10; dec_src2_p0 = 2'b01;
      end
      OP_LOAD: begin
        dec_legal_p0 = 1'b1; dec_reg_wr_p0 = 1'b1; dec_mem_read_p0 = 1'b1;
        dec_mux_p0 = 1'b1; dec_src2_p0 = 2'b01;
      end
      OP_STORE: begin
        dec_legal_p0 = 1'b1; dec_mem_write_p0 = 1'b1; dec_src2_p0 = 2'b01; uses_rs2_p0 = 1'b1;
      end
      OP_BRANCH: begin
        dec_legal_p0 = 1'b1; dec_ula_p0 = 2'b01; dec_branch_p0 = 1'b1; uses_rs2_p0 = 1'b1;
      end
      OP_LUI: begin
        dec_legal_p0 = 1'b1; dec_reg_wr_p0 = 1'b1; dec_src1_p0 = 2'b10;
        dec_src2_p0 = 2'b01; uses_rs1_p0 = 1'b0;
      end
      OP_AUIPC: begin
        dec_legal_p0 = 1'b1; dec_reg_wr_p0 = 1'b1; dec_src1_p0 = 2'b01;
        dec_src2_p0 = 2'b01; uses_rs1_p0 = 1'b0;
      end
      OP_JAL: begin
        dec_legal_p0 = 1'b1; dec_reg_wr_p0 = 1'b1; dec_src1_p0 = 2'b01;
        dec_src2_p0 = 2'b10; dec_jump_p0 = 1'b1; uses_rs1_p0 = 1'b0;
      end
      OP_JALR: begin
        dec_legal_p0 = 1'b1; dec_reg_wr_p0 = 1'b1; dec_src1_p0 = 2'b01;
        dec_src2_p0 = 2'b10; dec_jump_p0 = 1'b1;
      end
`ifdef CTRL_SYSTEM_EN
      OP_FENCE, OP_SYSTEM: dec_legal_p0 = 1'b1;
`endif
      default: ;
    endcase
  end

  assign id_jump   = id_valid & dec_jump_p0;
  assign id_branch = id_valid & dec_branch_p0;

  // A load in EX cannot forward to the very next instruction, so hold ID one cycle.
  assign load_use_stall_o = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                            ((uses_rs1_p0 & (ex_rd == id_rs1)) | (uses_rs2_p0 & (ex_rd == id_rs2)));

  assign bubble   = flush_i | load_use_stall_o | ~id_valid | ~dec_legal_p0;
  assign consumed = id_valid & ~stall_i & ~flush_i & ~load_use_stall_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_reg_wr      <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_mux_reg_wr  <= 1'b0;
      ex_ula_op      <= 2'b00;
      ex_alu_src1    <= 2'b00;
      ex_alu_src2    <= 2'b00;
      ex_rd          <= '0;
      mem_valid      <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_reg_wr     <= 1'b0;
      mem_mux_reg_wr <= 1'b0;
      mem_rd_idx     <= '0;
      wb_valid       <= 1'b0;
      wb_reg_wr      <= 1'b0;
      wb_mux_reg_wr  <= 1'b0;
      wb_rd          <= '0;
      ill_instr_o    <= 1'b0;
      ill_cnt        <= '0;
    end else begin
      ill_instr_o <= consumed & ~dec_legal_p0;
      if (!stall_i) begin
        // MEM -> WB
        wb_valid      <= mem_valid;
        wb_reg_wr     <= mem_reg_wr;
        wb_mux_reg_wr <= mem_mux_reg_wr;
        wb_rd         <= mem_rd_idx;
        // EX -> MEM
        mem_valid      <= ex_valid;
        mem_read       <= ex_mem_read;
        mem_write      <= ex_mem_write;
        mem_reg_wr     <= ex_reg_wr;
        mem_mux_reg_wr <= ex_mux_reg_wr;
        mem_rd_idx     <= ex_rd;
        // ID -> EX
        ex_valid      <= ~bubble;
        ex_reg_wr     <= ~bubble & dec_reg_wr_p0;
        ex_mem_read   <= ~bubble & dec_mem_read_p0;
        ex_mem_write  <= ~bubble & dec_mem_write_p0;
        ex_mux_reg_wr <= ~bubble & dec_mux_p0;
        ex_ula_op     <= bubble ? 2'b00 : dec_ula_p0;
        ex_alu_src1   <= bubble ? 2'b00 : dec_src1_p0;
        ex_alu_src2   <= bubble ? 2'b00 : dec_src2_p0;
        ex_rd         <= bubble ? '0 : id_rd;
        if (consumed && !dec_legal_p0)
          ill_cnt <= sat_inc(ill_cnt);
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: randomized and directed stimulus against a table-driven pipeline model.
// A second instance with ILL_CNT_W=2 exercises counter saturation.
module tb_ctrl_pipeline;

  localparam logic [6:0] OP_R = 7'b0110011, OP_IALU = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011, OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [6:0] id_opcode = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

  logic id_jump, id_branch, load_use_stall_o, ex_valid, mem_valid, mem_read, mem_write;
  logic wb_valid, wb_reg_wr, wb_mux_reg_wr, ill_instr_o;
  logic [1:0] ex_ula_op, ex_alu_src1, ex_alu_src2;
  logic [4:0] ex_rd, mem_rd_idx, wb_rd;
  logic [7:0] ill_cnt;

  logic b_id_jump, b_id_branch, b_load_use_stall_o, b_ex_valid, b_mem_valid, b_mem_read, b_mem_write;
  logic b_wb_valid, b_wb_reg_wr, b_wb_mux_reg_wr, b_ill_instr_o;
  logic [1:0] b_ex_ula_op, b_ex_alu_src1, b_ex_alu_src2;
  logic [4:0] b_ex_rd, b_mem_rd_idx, b_wb_rd;
  logic [1:0] b_ill_cnt;

  ctrl_pipeline #(.REG_ADDR_W(5), .ILL_CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .stall_i(stall_i), .flush_i(flush_i),
    .id_jump(id_jump), .id_branch(id_branch), .load_use_stall_o(load_use_stall_o),
    .ex_valid(ex_valid), .ex_ula_op(ex_ula_op), .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_mux_reg_wr(wb_mux_reg_wr),
    .ex_rd(ex_rd), .mem_rd_idx(mem_rd_idx), .wb_rd(wb_rd),
    .ill_instr_o(ill_instr_o), .ill_cnt(ill_cnt)
  );

  ctrl_pipeline #(.REG_ADDR_W(5), .ILL_CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .stall_i(stall_i), .flush_i(flush_i),
    .id_jump(b_id_jump), .id_branch(b_id_branch), .load_use_stall_o(b_load_use_stall_o),
    .ex_valid(b_ex_valid), .ex_ula_op(b_ex_ula_op), .ex_alu_src1(b_ex_alu_src1),
    .ex_alu_src2(b_ex_alu_src2), .mem_valid(b_mem_valid), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .wb_valid(b_wb_valid), .wb_reg_wr(b_wb_reg_wr),
    .wb_mux_reg_wr(b_wb_mux_reg_wr), .ex_rd(b_ex_rd), .mem_rd_idx(b_mem_rd_idx), .wb_rd(b_wb_rd),
    .ill_instr_o(b_ill_instr_o), .ill_cnt(b_ill_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one record per stage, shifted as whole instructions.
  typedef struct packed {
    logic       v, reg_wr, mem_read, mem_write, mux;
    logic [1:0] ula, s1, s2;
    logic [4:0] rd;
  } stg_t;

  stg_t m_ex, m_mem, m_wb;
  int   m_cnt;
  logic m_ill;

  logic [6:0] ops [12] = '{OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI,
                          OP_AUIPC, OP_JAL, OP_JALR, OP_FENCE, OP_SYSTEM, OP_BAD};

  // {legal, reg_wr, mem_read, mem_write, mux, ula[2], src1[2], src2[2], jump, branch}
  function automatic logic [12:0] spec_row(input logic [6:0] op);
    case (op)
      OP_R:              return {1'b1, 12'b1_0_0_0_10_00_00_0_0};
      OP_IALU:           return {1'b1, 12'b1_0_0_0_10_00_01_0_0};
      OP_LOAD:           return {1'b1, 12'b1_1_0_1_00_00_01_0_0};
      OP_STORE:          return {1'b1, 12'b0_0_1_0_00_00_01_0_0};
      OP_BRANCH:         return {1'b1, 12'b0_0_0_0_01_00_00_0_1};
      OP_LUI:            return {1'b1, 12'b1_0_0_0_00_10_01_0_0};
      OP_AUIPC:          return {1'b1, 12'b1_0_0_0_00_01_01_0_0};
      OP_JAL, OP_JALR:   return {1'b1, 12'b1_0_0_0_00_01_10_1_0};
`ifdef CTRL_SYSTEM_EN
      OP_FENCE, OP_SYSTEM: return {1'b1, 12'b0};
`endif
      default:           return 13'b0;
    endcase
  endfunction

  function automatic int cap(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic m_haz();
    logic u1, u2;
    u1 = !(id_opcode == OP_LUI || id_opcode == OP_AUIPC || id_opcode == OP_JAL);
    u2 = (id_opcode == OP_R || id_opcode == OP_STORE || id_opcode == OP_BRANCH);
    return id_valid && m_ex.v && m_ex.mem_read && (m_ex.rd != 0) &&
           ((u1 && m_ex.rd == id_rs1) || (u2 && m_ex.rd == id_rs2));
  endfunction

  function automatic logic [39:0] expv();
    logic [12:0] row;
    row = spec_row(id_opcode);
    return {id_valid & row[1], id_valid & row[0], m_haz(),
            m_ex.v, m_ex.ula, m_ex.s1, m_ex.s2,
            m_mem.v, m_mem.mem_read, m_mem.mem_write,
            m_wb.v, m_wb.reg_wr, m_wb.mux,
            m_ex.rd, m_mem.rd, m_wb.rd, m_ill, 8'(cap(m_cnt, 255))};
  endfunction

  function automatic logic [39:0] obs();
    return {id_jump, id_branch, load_use_stall_o, ex_valid, ex_ula_op, ex_alu_src1, ex_alu_src2,
            mem_valid, mem_read, mem_write, wb_valid, wb_reg_wr, wb_mux_reg_wr,
            ex_rd, mem_rd_idx, wb_rd, ill_instr_o, ill_cnt};
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; m_ill = 1'b0;
  endtask

  task automatic set_in(input logic v, input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd,
                        input logic st, input logic fl);
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    stall_i = st; flush_i = fl;
    #1;
  endtask

  task automatic tick();
    logic [12:0] row;
    logic        haz;
    @(posedge clk);
    row = spec_row(id_opcode);
    haz = m_haz();
    if (!stall_i) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      if (flush_i || haz || !id_valid || !row[12]) m_ex = '0;
      else m_ex = {1'b1, row[11:8], row[7:6], row[5:4], row[3:2], id_rd};
      m_ill = id_valid && !flush_i && !haz && !row[12];
      if (m_ill) m_cnt++;
    end else begin
      m_ill = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 7'd0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (obs() !== expv() || ex_valid !== 1'b0 || ill_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs(), expv());
    end
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL reset_release: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_pipe();
    set_in(1, OP_R, 1, 2, 5, 0, 0);
    tick();
    set_in(0, 7'd0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== expv() || ex_valid !== 1'b1 || ex_ula_op !== 2'b10) begin
      errors++; $display("FAIL pipe_ex: got %h want %h", obs(), expv());
    end
    tick();
    checks++;
    if (obs() !== expv() || mem_valid !== 1'b1) begin
      errors++; $display("FAIL pipe_mem: got %h want %h", obs(), expv());
    end
    tick();
    checks++;
    if (obs() !== expv() || wb_reg_wr !== 1'b1 || wb_rd !== 5'd5 || wb_mux_reg_wr !== 1'b0) begin
      errors++; $display("FAIL pipe_wb: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_load_use();
    set_in(1, OP_LOAD, 1, 0, 3, 0, 0);
    tick();
    set_in(1, OP_R, 1, 3, 4, 0, 0);
    checks++;
    if (obs() !== expv() || load_use_stall_o !== 1'b1) begin
      errors++; $display("FAIL lu_stall: got %h want %h", obs(), expv());
    end
    tick();
    checks++;
    if (obs() !== expv() || ex_valid !== 1'b0 || load_use_stall_o !== 1'b0 || mem_read !== 1'b1) begin
      errors++; $display("FAIL lu_bubble: got %h want %h", obs(), expv());
    end
    tick();
    set_in(0, 7'd0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== expv() || ex_valid !== 1'b1 || ex_rd !== 5'd4) begin
      errors++; $display("FAIL lu_resume: got %h want %h", obs(), expv());
    end
    set_in(1, OP_LOAD, 1, 0, 0, 0, 0);
    tick();
    set_in(1, OP_R, 0, 0, 4, 0, 0);
    checks++;
    if (obs() !== expv() || load_use_stall_o !== 1'b0) begin
      errors++; $display("FAIL lu_rd0: got %h want %h", obs(), expv());
    end
    tick();
  endtask

  task automatic test_flush();
    int cnt0;
    cnt0 = m_cnt;
    set_in(1, OP_JAL, 0, 0, 7, 0, 1);
    checks++;
    if (obs() !== expv() || id_jump !== 1'b1) begin
      errors++; $display("FAIL flush_jump: got %h want %h", obs(), expv());
    end
    tick();
    set_in(1, OP_BAD, 0, 0, 2, 0, 1);
    checks++;
    if (obs() !== expv() || ex_valid !== 1'b0 || ill_cnt !== 8'(cnt0)) begin
      errors++; $display("FAIL flush_bubble: got %h want %h", obs(), expv());
    end
    tick();
    checks++;
    if (obs() !== expv() || ill_instr_o !== 1'b0 || ill_cnt !== 8'(cnt0)) begin
      errors++; $display("FAIL flush_illegal: got %h want %h", obs(), expv());
    end
    set_in(1, OP_LOAD, 0, 0, 9, 0, 0);
    tick();
    set_in(1, OP_BAD, 9, 0, 1, 0, 1);
    checks++;
    if (obs() !== expv() || load_use_stall_o !== 1'b1) begin
      errors++; $display("FAIL flush_haz_comb: got %h want %h", obs(), expv());
    end
    tick();
    set_in(0, 7'd0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== expv() || ex_valid !== 1'b0 || ill_instr_o !== 1'b0 || ill_cnt !== 8'(cnt0)) begin
      errors++; $display("FAIL flush_haz: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_stall();
    set_in(1, OP_LOAD, 1, 0, 6, 0, 0);
    tick();
    set_in(1, OP_R, 1, 2, 8, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== expv() || ex_valid !== 1'b1 || ex_rd !== 5'd6 || mem_read !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got %h want %h", i, obs(), expv());
      end
    end
    set_in(1, OP_R, 1, 2, 8, 0, 0);
    tick();
    set_in(0, 7'd0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== expv() || mem_read !== 1'b1 || mem_rd_idx !== 5'd6 || ex_rd !== 5'd8) begin
      errors++; $display("FAIL stall_resume: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_illegal();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1, OP_BAD, 0, 0, 1, 0, 0);
      tick();
      checks++;
      if (obs() !== expv() || ill_instr_o !== 1'b1 || b_ill_cnt !== 2'(cap(m_cnt, 3))) begin
        errors++; $display("FAIL illegal_pulse%0d: got %h/%0d want %h/%0d",
                           i, obs(), b_ill_cnt, expv(), cap(m_cnt, 3));
      end
    end
    set_in(0, 7'd0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (ill_instr_o !== 1'b0 || ill_cnt !== 8'd5 || b_ill_cnt !== 2'd3) begin
      errors++; $display("FAIL illegal_count: got %0d/%0d/%0d want 0/5/3", ill_instr_o, ill_cnt, b_ill_cnt);
    end
    set_in(1, OP_SYSTEM, 0, 0, 1, 0, 0);
    tick();
    set_in(0, 7'd0, 0, 0, 0, 0, 0);
    checks++;
`ifdef CTRL_SYSTEM_EN
    if (obs() !== expv() || ill_cnt !== 8'd5 || ex_valid !== 1'b1) begin
`else
    if (obs() !== expv() || ill_cnt !== 8'd6 || ex_valid !== 1'b0) begin
`endif
      errors++; $display("FAIL illegal_system: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 8, ops[$urandom_range(0, 11)],
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random_comb%0d: got %h want %h", i, obs(), expv());
      end
      tick();
      checks++;
      if (obs() !== expv() || b_ill_cnt !== 2'(cap(m_cnt, 3))) begin
        errors++; $display("FAIL random_seq%0d: got %h/%0d want %h/%0d",
                           i, obs(), b_ill_cnt, expv(), cap(m_cnt, 3));
      end
    end
  endtask

  task automatic test_async_reset();
    set_in(1, OP_LOAD, 0, 0, 2, 0, 0);
    tick();
    set_in(1, OP_BAD, 0, 0, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs() !== expv() || ex_valid !== 1'b0 || ex_rd !== 5'd0 || ill_cnt !== 8'd0 || b_ill_cnt !== 2'd0) begin
      errors++; $display("FAIL async_reset: got %h want %h", obs(), expv());
    end
    #1 rst_n = 1'b1;
    set_in(0, 7'd0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL async_release: got %h want %h", obs(), expv());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pipe();
    test_load_use();
    test_flush();
    test_stall();
    test_illegal();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
